// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for hazard_forward_ctrl: select encodings, default widths, shadow entry.
// Build option FORWARDING_EN is consumed by the top, not here.
package hazard_forward_ctrl_pkg;

   localparam int REG_W_DEF = 4;
   localparam int CNT_W_DEF = 16;
   // Shadow dst is sized for the widest supported index; narrower indices zero-extend.
   localparam int REG_W_MAX = 8;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [REG_W_MAX-1:0] dst;
      logic                 wb_en;
      logic                 mem_read;
   } shadow_t;

   function automatic logic writes_reg(shadow_t e, logic [REG_W_MAX-1:0] idx);
      return e.valid & e.wb_en & (e.dst == idx);
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_match.sv
// Per-source RAW match against the EXE/MEM/WB shadows; returns match vector and
// youngest-producer select. Independent of FORWARDING_EN.
module hazard_match
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] i_src,
   input  logic             i_use,
   input  shadow_t          i_exe,
   input  shadow_t          i_mem,
   input  shadow_t          i_wb,
   output logic [2:0]       o_match,
   output logic [1:0]       o_sel
);

   logic [REG_W_MAX-1:0] w_src;
   logic                 w_unused;

   assign w_src = REG_W_MAX'(i_src);

   // o_match = {wb, mem, exe}; an unused source never matches.
   assign o_match[0] = i_use & writes_reg(i_exe, w_src);
   assign o_match[1] = i_use & writes_reg(i_mem, w_src);
   assign o_match[2] = i_use & writes_reg(i_wb,  w_src);

   assign o_sel = o_match[0] ? SEL_MEM :
                  o_match[1] ? SEL_WB  : SEL_REG;

   assign w_unused = ^{i_exe.mem_read, i_mem.mem_read, i_wb.mem_read};

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EXE-stage hazard controller: shadow pipeline, load-use stall, branch flush, counters.
// `define FORWARDING_EN for MEM/WB forwarding; otherwise stall until the producer retires.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src1,
   input  logic             id_use_src2,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_wb_en,
   input  logic             id_mem_read,
   input  logic             exe_branch_taken,
   output logic [1:0]       sel_src1,
   output logic [1:0]       sel_src2,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   shadow_t          r_exe_sh, r_mem_sh, r_wb_sh;
   shadow_t          w_id_sh;
   logic [1:0]       r_sel1, r_sel2;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic [2:0]       w_m1, w_m2;
   logic [1:0]       w_sel1, w_sel2, w_fwd1, w_fwd2;
   logic             w_hazard, w_issue, w_unused;

   hazard_match #(.REG_W(REG_W)) u_match1 (
      .i_src(id_src1), .i_use(id_use_src1),
      .i_exe(r_exe_sh), .i_mem(r_mem_sh), .i_wb(r_wb_sh),
      .o_match(w_m1), .o_sel(w_sel1)
   );

   hazard_match #(.REG_W(REG_W)) u_match2 (
      .i_src(id_src2), .i_use(id_use_src2),
      .i_exe(r_exe_sh), .i_mem(r_mem_sh), .i_wb(r_wb_sh),
      .o_match(w_m2), .o_sel(w_sel2)
   );

`ifdef FORWARDING_EN
   // Only a load still in EXE cannot be forwarded in time.
   assign w_hazard = (w_m1[0] | w_m2[0]) & r_exe_sh.mem_read;
   assign w_fwd1   = w_sel1;
   assign w_fwd2   = w_sel2;
`else
   assign w_hazard = |{w_m1, w_m2};
   assign w_fwd1   = SEL_REG;
   assign w_fwd2   = SEL_REG;
`endif

   assign flush   = exe_branch_taken & ~rst;
   assign stall   = id_valid & ~flush & w_hazard;
   assign w_issue = id_valid & ~stall & ~flush;

   always_comb begin
      w_id_sh = '0;
      if (w_issue) begin
         w_id_sh.valid    = 1'b1;
         w_id_sh.dst      = REG_W_MAX'(id_dst);
         w_id_sh.wb_en    = id_wb_en;
         w_id_sh.mem_read = id_mem_read;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exe_sh    <= '0;
         r_mem_sh    <= '0;
         r_wb_sh     <= '0;
         r_sel1      <= SEL_REG;
         r_sel2      <= SEL_REG;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_exe_sh <= w_id_sh;
         r_mem_sh <= r_exe_sh;
         r_wb_sh  <= r_mem_sh;
         r_sel1   <= w_issue ? w_fwd1 : SEL_REG;
         r_sel2   <= w_issue ? w_fwd2 : SEL_REG;
         if (stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign sel_src1    = r_sel1;
   assign sel_src2    = r_sel2;
   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;

   assign w_unused = ^{w_m1, w_m2, w_sel1, w_sel2,
                       r_exe_sh.mem_read, r_mem_sh.mem_read, r_wb_sh.mem_read};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: instruction-history model checked every cycle plus
// directed sequences with literal expectations; honours FORWARDING_EN.
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;
   localparam int REG_W = 4;
   localparam int CNT_W = 16;
   localparam int SAT_W = 5;
`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic id_valid = 1'b0, id_use_src1 = 1'b0, id_use_src2 = 1'b0;
   logic id_wb_en = 1'b0, id_mem_read = 1'b0, exe_branch_taken = 1'b0;
   logic [REG_W-1:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
   logic [1:0] sel_src1, sel_src2, s_sel1, s_sel2;
   logic stall, flush, s_stall, s_flush;
   logic [CNT_W-1:0] stall_count, flush_count;
   logic [SAT_W-1:0] s_stall_count, s_flush_count;

   int n_checks = 0, n_errors = 0;

   hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dst(id_dst),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
      .sel_src1(sel_src1), .sel_src2(sel_src2), .stall(stall), .flush(flush),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // Narrow-counter copy sharing the same stimulus, to reach saturation quickly.
   hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(SAT_W)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dst(id_dst),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
      .sel_src1(s_sel1), .sel_src2(s_sel2), .stall(s_stall), .flush(s_flush),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   always #5 clk = ~clk;

   function automatic void check(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endfunction

   // ---------------- model: what entered EXE 1, 2, 3 cycles ago ----------------
   typedef struct { bit v; int dst; bit wb; bit ld; } ins_t;
   ins_t hist [1:3];
   int   cnt_s = 0, cnt_f = 0;
   int   e_sel1 = 0, e_sel2 = 0;

   function automatic bit raw(int src, bit use_src);
      raw = 1'b0;
      for (int d = 1; d <= (FWD ? 1 : 3); d++)
         if (use_src && hist[d].v && hist[d].wb && hist[d].dst == src && (!FWD || hist[d].ld))
            raw = 1'b1;
   endfunction

   function automatic int fwd_sel(int src, bit use_src);
      fwd_sel = 0;
      if (FWD && use_src)
         for (int d = 2; d >= 1; d--)
            if (hist[d].v && hist[d].wb && hist[d].dst == src) fwd_sel = (d == 1) ? 1 : 2;
   endfunction

   function automatic int sat(int c, int w);
      int m;
      m = (1 << w) - 1;
      return (c > m) ? m : c;
   endfunction

   always @(negedge clk) begin : compare
      bit e_stall, e_flush, issue;
      if (rst) begin
         for (int k = 1; k <= 3; k++) hist[k] = '{1'b0, 0, 1'b0, 1'b0};
         cnt_s = 0; cnt_f = 0; e_sel1 = 0; e_sel2 = 0;
      end
      e_flush = exe_branch_taken && !rst;
      e_stall = !rst && id_valid && !e_flush &&
                (raw(int'(id_src1), id_use_src1) || raw(int'(id_src2), id_use_src2));
      check("stall",       int'(stall),         int'(e_stall));
      check("flush",       int'(flush),         int'(e_flush));
      check("sel_src1",    int'(sel_src1),      e_sel1);
      check("sel_src2",    int'(sel_src2),      e_sel2);
      check("stall_count", int'(stall_count),   sat(cnt_s, CNT_W));
      check("flush_count", int'(flush_count),   sat(cnt_f, CNT_W));
      check("sat_stall",   int'(s_stall),       int'(e_stall));
      check("sat_stall_count", int'(s_stall_count), sat(cnt_s, SAT_W));
      check("sat_flush_count", int'(s_flush_count), sat(cnt_f, SAT_W));
      if (!rst) begin
         issue  = id_valid && !e_stall && !e_flush;
         e_sel1 = issue ? fwd_sel(int'(id_src1), id_use_src1) : 0;
         e_sel2 = issue ? fwd_sel(int'(id_src2), id_use_src2) : 0;
         if (e_stall) cnt_s++;
         if (e_flush) cnt_f++;
         hist[3] = hist[2];
         hist[2] = hist[1];
         hist[1] = '{issue, int'(id_dst), id_wb_en, id_mem_read};
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit v, int s1, bit u1, int s2, bit u2, int d, bit wb, bit ld, bit br);
      id_valid = v; id_src1 = REG_W'(s1); id_use_src1 = u1; id_src2 = REG_W'(s2);
      id_use_src2 = u2; id_dst = REG_W'(d); id_wb_en = wb; id_mem_read = ld;
      exe_branch_taken = br;
   endtask

   task automatic idle(int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   // Holds an instruction in ID until it issues; returns after it has entered EXE.
   task automatic issue(input int s1, input bit u1, input int s2, input bit u2,
                        input int d, input bit wb, input bit ld, output int st);
      drive(1, s1, u1, s2, u2, d, wb, ld, 0);
      st = 0;
      #1;
      while (stall && st < 10) begin
         st++;
         tick();
         #1;
      end
      if (stall) check("issue_timeout", 1, 0);
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int st;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sel1", int'(sel_src1), 0);
      check("rst_sel2", int'(sel_src2), 0);
      check("rst_stall", int'(stall), 0);
      check("rst_flush", int'(flush), 0);
      check("rst_stall_count", int'(stall_count), 0);
      check("rst_flush_count", int'(flush_count), 0);
      #2 rst = 1'b0;
      tick();

      // ADD r1,r2,r3 ; SUB r2,r1,r3
      issue(2, 1, 3, 1, 1, 1, 0, st);
      issue(1, 1, 3, 1, 2, 1, 0, st);
      check("sub_stalls", st, FWD ? 0 : 3);
      check("sub_sel1", int'(sel_src1), FWD ? 1 : 0);
      check("sub_sel2", int'(sel_src2), 0);
      check("sub_stall_count", int'(stall_count), FWD ? 0 : 3);
      idle(4);

      // ADD r1 ; NOP ; ORR r4,r5,r1
      issue(2, 1, 3, 1, 1, 1, 0, st);
      idle(1);
      issue(5, 1, 1, 1, 4, 1, 0, st);
      check("orr_stalls", st, FWD ? 0 : 2);
      check("orr_sel1", int'(sel_src1), 0);
      check("orr_sel2", int'(sel_src2), FWD ? 2 : 0);
      check("orr_stall_count", int'(stall_count), FWD ? 0 : 5);
      idle(4);

      // LDR r1,[r2] ; ADD r2,r1,r1
      issue(2, 1, 0, 0, 1, 1, 1, st);
      issue(1, 1, 1, 1, 2, 1, 0, st);
      check("ldr_stalls", st, FWD ? 1 : 3);
      check("ldr_sel1", int'(sel_src1), FWD ? 2 : 0);
      check("ldr_sel2", int'(sel_src2), FWD ? 2 : 0);
      check("ldr_stall_count", int'(stall_count), FWD ? 1 : 8);
      idle(4);

      // LDR r1 ; dependent ADD in ID while the branch resolves taken
      issue(2, 1, 0, 0, 1, 1, 1, st);
      drive(1, 1, 1, 1, 1, 2, 1, 0, 1);
      #1;
      check("br_flush", int'(flush), 1);
      check("br_stall", int'(stall), 0);
      tick();
      check("br_flush_count", int'(flush_count), 1);
      check("br_bubble_sel1", int'(sel_src1), 0);
      check("br_bubble_sel2", int'(sel_src2), 0);
      issue(7, 1, 8, 1, 6, 1, 0, st);
      check("after_br_stalls", st, 0);
      check("after_br_sel1", int'(sel_src1), 0);
      check("after_br_sel2", int'(sel_src2), 0);
      check("after_br_stall_count", int'(stall_count), FWD ? 1 : 8);
      idle(4);

      // Reset asserted mid-hazard
      issue(2, 1, 0, 0, 1, 1, 1, st);
      drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
      #1;
      check("pre_rst_stall", int'(stall), 1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_stall", int'(stall), 0);
      check("mid_rst_flush", int'(flush), 0);
      check("mid_rst_sel1", int'(sel_src1), 0);
      check("mid_rst_sel2", int'(sel_src2), 0);
      check("mid_rst_stall_count", int'(stall_count), 0);
      check("mid_rst_flush_count", int'(flush_count), 0);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("post_rst_stall", int'(stall), 0);
      tick();
      check("post_rst_sel1", int'(sel_src1), 0);
      idle(4);

      // Saturation: self-dependent load held in ID, then a long run of taken branches
      drive(1, 1, 1, 0, 0, 1, 1, 1, 0);
      repeat (100) tick();
      idle(4);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (40) tick();
      idle(2);
      check("main_stall_count", int'(stall_count), FWD ? 50 : 75);
      check("main_flush_count", int'(flush_count), 40);
      check("sat_stall_hold", int'(s_stall_count), 31);
      check("sat_flush_hold", int'(s_flush_count), 31);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
